// File: rtl/csr_commit_unit_pkg.sv
// Shared CSR address map, widths, write-packet type and alias-group helpers
// for the CSR commit unit.
package csr_commit_unit_pkg;

   localparam int CSR_WIDTH     = 64;
   localparam int CSR_WIDTH_LOG = 12;

   localparam logic [CSR_WIDTH_LOG-1:0] CSR_FFLAGS  = 12'h001;
   localparam logic [CSR_WIDTH_LOG-1:0] CSR_FRM     = 12'h002;
   localparam logic [CSR_WIDTH_LOG-1:0] CSR_FCSR    = 12'h003;
   localparam logic [CSR_WIDTH_LOG-1:0] CSR_CYCLE   = 12'hC00;
   localparam logic [CSR_WIDTH_LOG-1:0] CSR_TIME    = 12'hC01;
   localparam logic [CSR_WIDTH_LOG-1:0] CSR_INSTRET = 12'hC02;

   // Generic writes land in scratch[addr low bits]; reads see them through this window.
   localparam int SCRATCH_SIZE  = 8;
   localparam int SCRATCH_IDX_W = $clog2(SCRATCH_SIZE);
   localparam logic [CSR_WIDTH_LOG-1:0] CSR_SCRATCH_BASE = 12'h340;

   typedef struct packed {
      logic [CSR_WIDTH_LOG-1:0] addr;
      logic [CSR_WIDTH-1:0]     data;
   } csrWrPkt;

   function automatic logic is_arch_csr(input logic [CSR_WIDTH_LOG-1:0] addr);
      return (addr == CSR_FFLAGS) || (addr == CSR_FRM)  || (addr == CSR_FCSR) ||
             (addr == CSR_CYCLE)  || (addr == CSR_TIME) || (addr == CSR_INSTRET);
   endfunction

   function automatic logic [7:0] fcsr_apply(input logic [7:0] fcsr, input csrWrPkt pkt);
      logic [7:0] f;
      f = fcsr;
      case (pkt.addr)
         CSR_FCSR:   f      = pkt.data[7:0];
         CSR_FRM:    f[7:5] = pkt.data[2:0];
         CSR_FFLAGS: f[4:0] = pkt.data[4:0];
         default:    f      = fcsr;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/csr_commit_unit_if.sv
// Execute/retire/read-port bundle of the CSR commit unit.
interface csr_commit_unit_if;
   import csr_commit_unit_pkg::*;

   logic                     csrWrEn_i;
   logic [CSR_WIDTH_LOG-1:0] csrWrAddr_i;
   logic [CSR_WIDTH-1:0]     csrWrData_i;
   logic                     commitCsr_i;
   logic [2:0]               commitCnt_i;
   logic [4:0]               fpFlags_i;
   logic                     flush_i;
   logic [CSR_WIDTH_LOG-1:0] csrRdAddr_i;
   logic [CSR_WIDTH-1:0]     csrRdData_o;
   logic                     full_o;
   logic                     empty_o;
   logic [2:0]               frm_o;
   logic                     err_o;

   modport master (
      output csrWrEn_i, csrWrAddr_i, csrWrData_i, commitCsr_i, commitCnt_i,
             fpFlags_i, flush_i, csrRdAddr_i,
      input  csrRdData_o, full_o, empty_o, frm_o, err_o
   );

   modport slave (
      input  csrWrEn_i, csrWrAddr_i, csrWrData_i, commitCsr_i, commitCnt_i,
             fpFlags_i, flush_i, csrRdAddr_i,
      output csrRdData_o, full_o, empty_o, frm_o, err_o
   );

endinterface

// File: rtl/csr_wr_fifo.sv
// Program-ordered pending CSR write buffer. With CSR_WR_FWD_EN defined it also
// exposes all pending entries, oldest first, for read forwarding.
module csr_wr_fifo
   import csr_commit_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk_sys,
   input  logic    rst_b,
   input  logic    push,
   input  logic    pop,
   input  logic    flush,
   input  csrWrPkt din,
   output csrWrPkt head,
   output logic    full,
   output logic    empty,
   output logic    overflow,
   output logic    underflow
`ifdef CSR_WR_FWD_EN
   ,
   output csrWrPkt          pend [DEPTH],
   output logic [DEPTH-1:0] pend_vld
`endif
);

   localparam int AW = $clog2(DEPTH);

   csrWrPkt       mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          pop_ok;
   logic          push_ok;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok    = pop & ~empty;
   // A pop frees a slot in the same cycle, so push-while-full is legal alongside it.
   assign push_ok   = push & ~flush & (~full | pop_ok);
   assign overflow  = push & ~flush & full & ~pop_ok;
   assign underflow = pop & empty;
   assign head      = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
   end

`ifdef CSR_WR_FWD_EN
   logic [AW:0] count;
   assign count = wr_ptr - rd_ptr;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         pend[i]     = mem[AW'(rd_ptr[AW-1:0] + AW'(i))];
         pend_vld[i] = ((AW+1)'(i) < count);
      end
   end
`endif

endmodule

// File: rtl/csr_commit_unit.sv
// Architectural CSR file with commit-ordered write buffer, counters and the
// FCSR/FRM/FFLAGS alias group. Optional read forwarding: CSR_WR_FWD_EN.
module csr_commit_unit
   import csr_commit_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   csr_commit_unit_if.slave   bus
);

   csrWrPkt              din;
   csrWrPkt              head;
   logic                 overflow;
   logic                 underflow;
   logic                 commit_ok;
   logic [7:0]           fcsr;
   logic [7:0]           fcsr_nxt;
   logic [7:0]           rd_fcsr;
   logic [63:0]          cycle_cnt;
   logic [63:0]          time_cnt;
   logic [63:0]          instret_cnt;
   logic [CSR_WIDTH-1:0] scratch [SCRATCH_SIZE];
   logic                 err;

   assign din.addr = bus.csrWrAddr_i;
   assign din.data = bus.csrWrData_i;

`ifdef CSR_WR_FWD_EN
   csrWrPkt          pend [DEPTH];
   logic [DEPTH-1:0] pend_vld;
`endif

   csr_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_sys   (clk),
      .rst_b     (reset_n),
      .push      (bus.csrWrEn_i),
      .pop       (bus.commitCsr_i),
      .flush     (bus.flush_i),
      .din       (din),
      .head      (head),
      .full      (bus.full_o),
      .empty     (bus.empty_o),
      .overflow  (overflow),
      .underflow (underflow)
`ifdef CSR_WR_FWD_EN
      ,
      .pend      (pend),
      .pend_vld  (pend_vld)
`endif
   );

   assign commit_ok = bus.commitCsr_i & ~bus.empty_o;

   // Retired FP flags are ORed on top of any same-cycle committed FCSR/FFLAGS write.
   always_comb begin
      fcsr_nxt      = commit_ok ? fcsr_apply(fcsr, head) : fcsr;
      fcsr_nxt[4:0] = fcsr_nxt[4:0] | bus.fpFlags_i;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fcsr        <= '0;
         cycle_cnt   <= '0;
         time_cnt    <= '0;
         instret_cnt <= '0;
         err         <= 1'b0;
         for (int i = 0; i < SCRATCH_SIZE; i++) scratch[i] <= '0;
      end else begin
         fcsr        <= fcsr_nxt;
         cycle_cnt   <= cycle_cnt + 64'd1;
         time_cnt    <= time_cnt + 64'd1;
         instret_cnt <= instret_cnt + 64'(bus.commitCnt_i);
         err         <= err | overflow | underflow;
         if (commit_ok && !is_arch_csr(head.addr))
            scratch[head.addr[SCRATCH_IDX_W-1:0]] <= head.data;
      end
   end

`ifdef CSR_WR_FWD_EN
   logic                 fwd_hit;
   logic [CSR_WIDTH-1:0] fwd_data;

   // Replaying pending writes oldest-first merges aliases and leaves the youngest match.
   always_comb begin
      rd_fcsr  = fcsr;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (pend_vld[i]) begin
            rd_fcsr = fcsr_apply(rd_fcsr, pend[i]);
            if (pend[i].addr == bus.csrRdAddr_i && !is_arch_csr(pend[i].addr)) begin
               fwd_hit  = 1'b1;
               fwd_data = pend[i].data;
            end
         end
      end
   end
`else
   assign rd_fcsr = fcsr;
`endif

   always_comb begin
      bus.csrRdData_o = '0;
      case (bus.csrRdAddr_i)
         CSR_FFLAGS:  bus.csrRdData_o = CSR_WIDTH'(rd_fcsr[4:0]);
         CSR_FRM:     bus.csrRdData_o = CSR_WIDTH'(rd_fcsr[7:5]);
         CSR_FCSR:    bus.csrRdData_o = CSR_WIDTH'(rd_fcsr);
         CSR_CYCLE:   bus.csrRdData_o = CSR_WIDTH'(cycle_cnt);
         CSR_TIME:    bus.csrRdData_o = CSR_WIDTH'(time_cnt);
         CSR_INSTRET: bus.csrRdData_o = CSR_WIDTH'(instret_cnt);
         default: begin
`ifdef CSR_WR_FWD_EN
            if (fwd_hit)
               bus.csrRdData_o = fwd_data;
            else
`endif
            if (bus.csrRdAddr_i[CSR_WIDTH_LOG-1:SCRATCH_IDX_W] ==
                CSR_SCRATCH_BASE[CSR_WIDTH_LOG-1:SCRATCH_IDX_W])
               bus.csrRdData_o = scratch[bus.csrRdAddr_i[SCRATCH_IDX_W-1:0]];
         end
      endcase
   end

   assign bus.frm_o = fcsr[7:5];
   assign bus.err_o = err;

endmodule

// File: tb/tb_csr_commit_unit.sv
// Directed self-checking bench for csr_commit_unit (DEPTH=2); expectations
// follow CSR_WR_FWD_EN when it is defined for the build.
module tb_csr_commit_unit;
   import csr_commit_unit_pkg::*;

   logic clk;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   csr_commit_unit_if bus ();

   csr_commit_unit #(.DEPTH(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [11:0] a, input string tag, input logic [63:0] exp);
      bus.csrRdAddr_i = a;
      #1;
      check(tag, bus.csrRdData_o, exp);
   endtask

   task automatic set_wr(input logic en, input logic [11:0] a, input logic [63:0] d);
      bus.csrWrEn_i   = en;
      bus.csrWrAddr_i = a;
      bus.csrWrData_i = d;
   endtask

   initial begin
      logic [63:0] frm_spec;
`ifdef CSR_WR_FWD_EN
      frm_spec = 64'd5;
`else
      frm_spec = 64'd0;
`endif
      reset_n = 1'b0;
      set_wr(1'b0, 12'h0, 64'h0);
      bus.commitCsr_i = 1'b0;
      bus.commitCnt_i = 3'd0;
      bus.fpFlags_i   = 5'd0;
      bus.flush_i     = 1'b0;
      bus.csrRdAddr_i = 12'h0;
      tick(2);
      check("rst_empty", bus.empty_o, 1);
      check("rst_full", bus.full_o, 0);
      check("rst_err", bus.err_o, 0);
      check("rst_frm", bus.frm_o, 0);
      rd(CSR_FCSR, "rst_fcsr", 64'h0);

      // Ten edges after release -> counters read 10
      reset_n = 1'b1;
      tick(10);
      rd(CSR_CYCLE, "cycle10", 64'd10);
      rd(CSR_TIME, "time10", 64'd10);
      rd(CSR_FCSR, "fcsr0", 64'h0);

      // Pending FRM write, then commit
      set_wr(1'b1, CSR_FRM, 64'd5);
      tick(1);
      set_wr(1'b0, 12'h0, 64'h0);
      check("push_empty", bus.empty_o, 0);
      rd(CSR_FRM, "frm_pending", frm_spec);
      check("frm_o_pending", bus.frm_o, 0);
      bus.commitCsr_i = 1'b1;
      tick(1);
      bus.commitCsr_i = 1'b0;
      check("frm_o_commit", bus.frm_o, 5);
      rd(CSR_FRM, "frm_commit", 64'd5);
      rd(CSR_FCSR, "fcsr_a0", 64'hA0);
      check("commit_empty", bus.empty_o, 1);

      // Fill, overflow, push+pop while full
      set_wr(1'b1, CSR_FFLAGS, 64'h1);
      tick(1);
      set_wr(1'b1, 12'h341, 64'hDEADBEEF);
      tick(1);
      check("full2", bus.full_o, 1);
      set_wr(1'b1, 12'h342, 64'h11);
      tick(1);
      check("ovf_err", bus.err_o, 1);
      check("ovf_full", bus.full_o, 1);
      set_wr(1'b1, 12'h343, 64'h22);
      bus.commitCsr_i = 1'b1;
      tick(1);
      set_wr(1'b0, 12'h0, 64'h0);
      check("pushpop_full", bus.full_o, 1);
      rd(CSR_FFLAGS, "fflags1", 64'h1);
      tick(1);
      rd(12'h341, "scratch341", 64'hDEADBEEF);
      tick(1);
      bus.commitCsr_i = 1'b0;
      rd(12'h343, "scratch343", 64'h22);
      rd(12'h342, "scratch342_dropped", 64'h0);
      check("drain_empty", bus.empty_o, 1);

      // Flush beats a same-cycle push
      set_wr(1'b1, CSR_FFLAGS, 64'h0);
      tick(1);
      set_wr(1'b1, CSR_FFLAGS, 64'h1F);
      bus.flush_i = 1'b1;
      tick(1);
      set_wr(1'b0, 12'h0, 64'h0);
      bus.flush_i = 1'b0;
      check("flush_empty", bus.empty_o, 1);
      rd(CSR_FFLAGS, "flush_fflags", 64'h1);

      // Flush with commit: head still retires
      set_wr(1'b1, CSR_FRM, 64'd3);
      tick(1);
      set_wr(1'b1, CSR_FRM, 64'd1);
      tick(1);
      set_wr(1'b0, 12'h0, 64'h0);
      bus.commitCsr_i = 1'b1;
      bus.flush_i     = 1'b1;
      tick(1);
      bus.commitCsr_i = 1'b0;
      bus.flush_i     = 1'b0;
      check("flushcommit_frm", bus.frm_o, 3);
      check("flushcommit_empty", bus.empty_o, 1);
      rd(CSR_FCSR, "flushcommit_fcsr", 64'h61);

      // Reset mid-operation drops pending entry; then commit-when-empty
      set_wr(1'b1, CSR_FCSR, 64'hFF);
      tick(1);
      set_wr(1'b0, 12'h0, 64'h0);
      reset_n = 1'b0;
      #1;
      check("midrst_empty", bus.empty_o, 1);
      check("midrst_err", bus.err_o, 0);
      rd(CSR_FCSR, "midrst_fcsr", 64'h0);
      tick(1);
      reset_n = 1'b1;
      bus.commitCsr_i = 1'b1;
      tick(1);
      bus.commitCsr_i = 1'b0;
      check("udf_err", bus.err_o, 1);
      check("udf_empty", bus.empty_o, 1);
      rd(CSR_FCSR, "udf_fcsr", 64'h0);

      // FP flag accumulate onto committed FFLAGS
      set_wr(1'b1, CSR_FFLAGS, 64'h1);
      tick(1);
      set_wr(1'b0, 12'h0, 64'h0);
      bus.commitCsr_i = 1'b1;
      bus.fpFlags_i   = 5'h04;
      tick(1);
      bus.commitCsr_i = 1'b0;
      bus.fpFlags_i   = 5'h00;
      rd(CSR_FFLAGS, "fflags_acc", 64'h5);

      // instret accumulation and read-only write
      bus.commitCnt_i = 3'd4;
      tick(3);
      bus.commitCnt_i = 3'd0;
      rd(CSR_INSTRET, "instret12", 64'd12);
      set_wr(1'b1, CSR_INSTRET, 64'h100);
      tick(1);
      set_wr(1'b0, 12'h0, 64'h0);
      rd(CSR_INSTRET, "instret_pending", 64'd12);
      bus.commitCsr_i = 1'b1;
      tick(1);
      bus.commitCsr_i = 1'b0;
      rd(CSR_INSTRET, "instret_ro", 64'd12);
      rd(12'h7FF, "unmapped", 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/csr_commit_unit.md
# csr_commit_unit

Architectural CSR file and commit-ordered write buffer that sinks the speculative CSR write requests (`csrWrEn`/`csrWrAddr`/`csrWrData`) produced by the control ALU in the execute stage. Requests are queued in program order and applied to architectural state only when the retire logic commits the owning instruction; a pipeline flush discards them. The unit also sources CSR read data back to register read (the control ALU's `data2` operand). It maintains the cycle, time and instret counters and the FCSR/FRM/FFLAGS alias group.

## Interface
- `DEPTH`, 2: pending-write buffer entries (power of two, ≥2).
- `clk`  in  1  core clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `csrWrEn_i`  in  1  speculative write request from execute.
- `csrWrAddr_i`  in  `CSR_WIDTH_LOG`  CSR address (fn12).
- `csrWrData_i`  in  `CSR_WIDTH`  value to write.
- `commitCsr_i`  in  1  retire of the oldest pending CSR instruction.
- `commitCnt_i`  in  3  instructions retired this cycle (0..`COMMIT_WIDTH`).
- `fpFlags_i`  in  5  retired FP exception flags, OR-accumulated into FFLAGS.
- `flush_i`  in  1  squash all pending writes.
- `csrRdAddr_i`  in  `CSR_WIDTH_LOG`  read address.
- `csrRdData_o`  out  `CSR_WIDTH`  read data, combinational.
- `full_o`  out  1  buffer holds `DEPTH` entries.
- `empty_o`  out  1  buffer holds 0 entries.
- `frm_o`  out  3  current rounding mode to the FP units.
- `err_o`  out  1  sticky protocol error (overflow or commit-when-empty).

## Operation
- Buffer: circular FIFO, head/tail pointers of log2(`DEPTH`)+1 bits (wrap bit distinguishes full/empty). Push on `csrWrEn_i`; pop on `commitCsr_i`.
- On pop, the head entry writes architectural state:
  - `CSR_FCSR` writes fcsr[7:0].
  - `CSR_FRM` writes fcsr[7:5] from data[2:0].
  - `CSR_FFLAGS` writes fcsr[4:0] from data[4:0].
  - `CSR_CYCLE`/`CSR_TIME`/`CSR_INSTRET` writes are ignored (read-only).
  - Any other address writes a generic scratch array indexed by the address low bits; array size is set in the package.
- Reads: FFLAGS = {0, fcsr[4:0]}, FRM = {0, fcsr[7:5]}, FCSR = {0, fcsr[7:0]}, counters return their current value zero-extended or truncated to `CSR_WIDTH`. Unmapped addresses read 0.
- Counters: cycle and time increment by 1 every cycle. instret increments by `commitCnt_i`. All counters are 64-bit and wrap modulo 2^64.
- FFLAGS accumulate: fcsr[4:0] |= `fpFlags_i` each cycle. A same-cycle commit write to FFLAGS/FCSR takes precedence, and the accumulate is then ORed onto the written value.
- Boundary rules:
  - Push when full with no pop: dropped, `err_o` set.
  - Push and pop when full: both performed.
  - Pop when empty: ignored, `err_o` set.
  - `flush_i` with push: flush wins, push dropped.
  - `flush_i` with `commitCsr_i`: the commit write is applied, then the remaining entries are cleared.
- `err_o` clears only on reset.

## Timing
- Reset (async, `reset_n` low): pointers 0, `empty_o`=1, `full_o`=0, `err_o`=0, fcsr=0 (`frm_o`=0), counters 0, scratch array 0. `csrRdData_o` therefore reads 0 for all addresses.
- Push latency: an entry is counted in `full_o`/`empty_o` one cycle after `csrWrEn_i`.
- Commit latency: the architectural value is visible on `csrRdData_o` and `frm_o` the cycle after `commitCsr_i`.
- Counter reads return the registered value, i.e. the count as of the previous edge.
- Reset asserted mid-operation discards all pending entries immediately; no partial commit.

## Configuration
- `CSR_WR_FWD_EN` defined: `csrRdData_o` forwards from the youngest pending entry whose address equals `csrRdAddr_i`, honoring the FRM/FFLAGS/FCSR alias merge. Committed state is used if no entry matches.
- `CSR_WR_FWD_EN` undefined: reads see committed state only. Dispatch must serialize CSR instructions.

## Structure
- Shared package: the `CSR_*` address constants, `CSR_WIDTH`, `CSR_WIDTH_LOG`, a `csrWrPkt` typedef {addr, data}, and the scratch-array size constant.
- Natural sub-module: `csr_wr_fifo` (parameterized `DEPTH`, push/pop/flush, full/empty/overflow/underflow). The alias and counter logic stays in the top module.

## Test plan
- Reset, then read `CSR_CYCLE` after 10 cycles -> 9 (or 10 per edge alignment, checked against the cycle model). Read `CSR_FCSR` -> 0.
- Push FRM=3'b101, no commit, read FRM -> 0 without `CSR_WR_FWD_EN` and 5 with it. Commit -> FRM=5 and `frm_o`=5 next cycle, FCSR=0xA0.
- Push two writes (`full_o`=1 with `DEPTH`=2), push a third with no pop -> dropped, `err_o`=1. Push and pop in the same cycle while full -> count stays 2.
- Push FFLAGS=0x01, then `flush_i` in the same cycle as a second push -> `empty_o`=1 next cycle, FFLAGS unchanged.
- `fpFlags_i`=0x04 while committing FFLAGS=0x01 -> FFLAGS=0x05.
- `commitCnt_i`=4 for 3 cycles -> instret=12. A push to `CSR_INSTRET` followed by commit -> instret unaffected.
